load_sweep_sequencer: RTL and testbench

//  Sequences power-estimation load banks through a stepped ramp-up, hold and ramp-down sweep.
//  - Drives a thermometer-coded enable mask to NUM_BANKS toggle-load banks.
//  - Holds each level for a fixed dwell, so board current can be measured at each step.
//  - Mirrors the active mask on the board LEDs.
//  - Top-level resource controller, clocked from the 100 MHz board clock.

---
 rtl/load_sweep_sequencer_if.sv | 23 ++
 rtl/load_sweep_sequencer.sv | 143 ++++++++++++++
 tb/tb_load_sweep_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/load_sweep_sequencer_if.sv
// Control/status bundle for the load sweep sequencer.
// master drives start/abort; slave (the sequencer) drives the bank enables and status.
interface load_sweep_sequencer_if #(
    parameter int NUM_BANKS = 16
);
    logic                 start;
    logic                 abort;
    logic [NUM_BANKS-1:0] bank_en;
    logic [15:0]          leds;
    logic [5:0]           level;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort,
        input  bank_en, leds, level, busy, done
    );

    modport slave (
        input  start, abort,
        output bank_en, leds, level, busy, done
    );
endinterface

// File: rtl/load_sweep_sequencer.sv
// Stepped ramp-up / hold / ramp-down sweep of thermometer-coded load bank enables.
// Define LOAD_SWEEP_LOOP_EN to restart the sweep automatically after each DONE cycle.
//
// state      | meaning
// IDLE       | all banks off, waiting for start
// RAMP_UP    | level rising by one bank every DWELL_CYCLES
// HOLD       | all banks on for HOLD_CYCLES
// RAMP_DOWN  | level falling by one bank every DWELL_CYCLES, level 0 dwelled too
// DONE       | one-cycle completion pulse
module load_sweep_sequencer #(
    parameter int NUM_BANKS    = 16,
    parameter int DWELL_CYCLES = 50000000,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic                   clk100m,
    input  logic                   rstn,
    load_sweep_sequencer_if.slave  sweep
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD,
        ST_RAMP_DOWN,
        ST_DONE
    } state_t;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [5:0]  LEVEL_MAX  = 6'(NUM_BANKS);

    state_t               state_q, state_d;
    logic [5:0]           level_q, level_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
    logic [15:0]          leds_q, leds_d;

    always_ff @(posedge clk100m) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bank_en_q <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bank_en_q <= bank_en_d;
            leds_q    <= leds_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q + 32'd1;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sweep.start) begin
                    state_d = ST_RAMP_UP;
                    level_d = 6'd1;
                end
            end
            ST_RAMP_UP: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 6'd1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RAMP_DOWN;
                    level_d = LEVEL_MAX - 6'd1;
                end
            end
            ST_RAMP_DOWN: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (level_q != 6'd0) begin
                        level_d = level_q - 6'd1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                cnt_d = '0;
`ifdef LOAD_SWEEP_LOOP_EN
                state_d = ST_RAMP_UP;
                level_d = 6'd1;
`else
                state_d = ST_IDLE;
                level_d = 6'd0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                level_d = '0;
                cnt_d   = '0;
            end
        endcase

        // abort overrides every transition above, including DONE
        if (sweep.abort) begin
            state_d = ST_IDLE;
            level_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_HOLD) || (state_d == ST_RAMP_DOWN);

        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_en_d[i] = (level_d > 6'(i));
        end
        for (int i = 0; i < 16; i++) begin
            leds_d[i] = (i < NUM_BANKS) && (level_d > 6'(i));
        end
    end

    assign sweep.bank_en = bank_en_q;
    assign sweep.leds    = leds_q;
    assign sweep.level   = level_q;
    assign sweep.busy    = busy_q;
    assign sweep.done    = done_q;

endmodule

// File: tb/tb_load_sweep_sequencer.sv
// Self-checking bench for load_sweep_sequencer: timeline model of the sweep plus directed literal checks.
// Build with LOAD_SWEEP_LOOP_EN defined to exercise the repeating-sweep variant.
module tb_load_sweep_sequencer;

    localparam int NB     = 4;
    localparam int DW     = 3;
    localparam int HD     = 5;
    localparam int T_DONE = 2 * NB * DW + HD;

    logic clk100m = 1'b0;
    logic rstn    = 1'b0;

    int checks = 0;
    int errors = 0;

    load_sweep_sequencer_if #(.NUM_BANKS(NB)) sw ();

    load_sweep_sequencer #(
        .NUM_BANKS   (NB),
        .DWELL_CYCLES(DW),
        .HOLD_CYCLES (HD)
    ) dut (
        .clk100m(clk100m),
        .rstn   (rstn),
        .sweep  (sw)
    );

    always #5 clk100m = ~clk100m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a timeline indexed by cycles since the start edge.
    bit m_valid  = 0;
    bit m_active = 0;
    int m_t      = 0;

    always @(posedge clk100m) begin
        if (!rstn) m_valid = 1;
        if (!rstn || sw.abort) begin
            m_active = 0;
        end else if (!m_active) begin
            if (sw.start) begin
                m_active = 1;
                m_t      = 0;
            end
        end else if (m_t == T_DONE) begin
`ifdef LOAD_SWEEP_LOOP_EN
            m_t = 0;
`else
            m_active = 0;
`endif
        end else begin
            m_t++;
        end
    end

    function automatic int exp_level();
        if (!m_active)                 return 0;
        if (m_t < NB * DW)             return m_t / DW + 1;
        if (m_t < NB * DW + HD)        return NB;
        if (m_t < T_DONE)              return NB - 1 - (m_t - NB * DW - HD) / DW;
        return 0;
    endfunction

    always @(negedge clk100m) begin
        if (m_valid) begin
            int lvl;
            lvl = exp_level();
            check("model_level",   32'(sw.level),   32'(lvl));
            check("model_bank_en", 32'(sw.bank_en), (32'd1 << lvl) - 32'd1);
            check("model_leds",    32'(sw.leds),    (32'd1 << lvl) - 32'd1);
            check("model_busy",    32'(sw.busy),    32'(m_active && m_t < T_DONE));
            check("model_done",    32'(sw.done),    32'(m_active && m_t == T_DONE));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk100m);
    endtask

    // Full sweep from IDLE; optional extra start pulse at trace index pulse_at.
    task automatic run_sweep(input string tag, input int pulse_at);
        logic [3:0] be_tr [0:30];
        logic       bz_tr [0:30];
        logic       dn_tr [0:30];
        int busy_cnt;
        sw.start = 1'b1;
        step(1);
        sw.start = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            be_tr[k] = sw.bank_en;
            bz_tr[k] = sw.busy;
            dn_tr[k] = sw.done;
            sw.start = (k == pulse_at);
            step(1);
        end
        sw.start = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k <= 30; k++) if (bz_tr[k]) busy_cnt++;
        check({tag, "_k0_bank"},  32'(be_tr[0]),  32'h1);
        check({tag, "_k3_bank"},  32'(be_tr[3]),  32'h3);
        check({tag, "_k6_bank"},  32'(be_tr[6]),  32'h7);
        check({tag, "_k9_bank"},  32'(be_tr[9]),  32'hF);
        check({tag, "_k16_bank"}, 32'(be_tr[16]), 32'hF);
        check({tag, "_k17_bank"}, 32'(be_tr[17]), 32'h7);
        check({tag, "_k20_bank"}, 32'(be_tr[20]), 32'h3);
        check({tag, "_k23_bank"}, 32'(be_tr[23]), 32'h1);
        check({tag, "_k26_bank"}, 32'(be_tr[26]), 32'h0);
        check({tag, "_k28_busy"}, 32'(bz_tr[28]), 32'h1);
        check({tag, "_k28_done"}, 32'(dn_tr[28]), 32'h0);
        check({tag, "_k29_done"}, 32'(dn_tr[29]), 32'h1);
        check({tag, "_k29_busy"}, 32'(bz_tr[29]), 32'h0);
        check({tag, "_k30_done"}, 32'(dn_tr[30]), 32'h0);
`ifdef LOAD_SWEEP_LOOP_EN
        check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd30);
        check({tag, "_k30_bank"}, 32'(be_tr[30]), 32'h1);
        check({tag, "_k30_busy"}, 32'(bz_tr[30]), 32'h1);
`else
        check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd29);
        check({tag, "_k30_bank"}, 32'(be_tr[30]), 32'h0);
        check({tag, "_k30_busy"}, 32'(bz_tr[30]), 32'h0);
`endif
        sw.abort = 1'b1;
        step(1);
        sw.abort = 1'b0;
        step(1);
    endtask

    initial begin
        sw.start = 1'b0;
        sw.abort = 1'b0;
        rstn     = 1'b0;
        step(3);
        rstn = 1'b1;
        step(2);
        check("reset_bank", 32'(sw.bank_en), 32'h0);
        check("reset_leds", 32'(sw.leds),    32'h0);
        check("reset_busy", 32'(sw.busy),    32'h0);
        check("reset_done", 32'(sw.done),    32'h0);

        run_sweep("sweep", -1);

        // abort during RAMP_UP at level 2
        sw.start = 1'b1;
        step(1);
        sw.start = 1'b0;
        step(3);
        check("abort_pre_level", 32'(sw.level), 32'd2);
        sw.abort = 1'b1;
        step(1);
        sw.abort = 1'b0;
        check("abort_bank",  32'(sw.bank_en), 32'h0);
        check("abort_busy",  32'(sw.busy),    32'h0);
        check("abort_done",  32'(sw.done),    32'h0);
        step(3);
        check("abort_stays_idle", 32'(sw.busy), 32'h0);

        run_sweep("hold_start", 12);

        // simultaneous start and abort in IDLE
        sw.start = 1'b1;
        sw.abort = 1'b1;
        step(1);
        sw.start = 1'b0;
        sw.abort = 1'b0;
        check("both_bank", 32'(sw.bank_en), 32'h0);
        check("both_busy", 32'(sw.busy),    32'h0);
        step(2);

        // reset during HOLD
        sw.start = 1'b1;
        step(1);
        sw.start = 1'b0;
        step(12);
        check("pre_rst_bank", 32'(sw.bank_en), 32'hF);
        rstn = 1'b0;
        step(1);
        check("rst_bank",  32'(sw.bank_en), 32'h0);
        check("rst_leds",  32'(sw.leds),    32'h0);
        check("rst_level", 32'(sw.level),   32'h0);
        check("rst_busy",  32'(sw.busy),    32'h0);
        rstn = 1'b1;
        step(1);
        run_sweep("after_rst", -1);

        // start held high across a sweep; model covers the retrigger timing
        sw.start = 1'b1;
        step(T_DONE + 4);
        check("held_start_busy", 32'(sw.busy), 32'h1);
        sw.start = 1'b0;
        sw.abort = 1'b1;
        step(1);
        sw.abort = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
